// File: rtl/time_set_keys.sv
// time_set_keys
//   Push-button front end for the countdown timer core. Each raw button is
//   synchronised (2 flops), debounced and rise-detected. The hour/min/sec
//   buttons auto-repeat while held; enter/start/clr fire once per press.
//   The block also keeps the hour/min/sec preset values loaded by the timer.
//
// Ports
//   clk, rst                       clock; asynchronous active-high reset
//   btn_hour/min/sec/enter/start/clr  raw active-high buttons (async to clk)
//   key_hour_up/min_up/sec_up      one-cycle pulse per accepted press or repeat
//   key_enter                      one-cycle pulse per accepted press
//   key_start                      run level, toggles per accepted start press
//   hour_set/min_set/sec_set       wrapped binary presets (0..HOUR_MAX / MS_MAX)
module time_set_keys #(
  parameter int DEB_CYCLES = 1000000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 10000000,
  parameter int HOUR_MAX   = 23,
  parameter int MS_MAX     = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_enter,
  input  logic       btn_start,
  input  logic       btn_clr,
  output logic       key_hour_up,
  output logic       key_min_up,
  output logic       key_sec_up,
  output logic       key_enter,
  output logic       key_start,
  output logic [7:0] hour_set,
  output logic [7:0] min_set,
  output logic [7:0] sec_set
);

  localparam int NBTN      = 6;
  localparam int NREP      = 3;
  localparam int IDX_ENTER = 3;
  localparam int IDX_START = 4;
  localparam int IDX_CLR   = 5;

  // Debounce counter only needs to reach DEB_CYCLES-1 before the level flips.
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);

  localparam logic [7:0] HOUR_LIM = 8'(HOUR_MAX);
  localparam logic [7:0] MS_LIM   = 8'(MS_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  logic [NBTN-1:0] btn_raw_s;
  logic [NBTN-1:0] rise_s;
  logic [NREP-1:0] deb_s;
  logic [NREP-1:0] up_d_s;

  assign btn_raw_s = {btn_clr, btn_start, btn_enter, btn_sec, btn_min, btn_hour};

  // ---------------------------------------------------------------------
  // Per-button synchroniser, debouncer and rise detector
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_prev_q;
    logic [DEB_W-1:0] cnt_q;

    // Counter runs only while the synchronised level disagrees with the
    // debounced level; any agreeing cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= btn_raw_s[g];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEB_LAST) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + DEB_W'(1);
        end
      end
    end

    assign rise_s[g] = deb_q & ~deb_prev_q;

    if (g < NREP) begin : g_lvl
      assign deb_s[g] = deb_q;
    end
  end

  // ---------------------------------------------------------------------
  // Auto-repeat FSMs for hour / min / sec
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NREP; g++) begin : g_rep
    rep_state_e       state_q;
    rep_state_e       state_d;
    logic [REP_W-1:0] cnt_q;
    logic [REP_W-1:0] cnt_d;
    logic             pulse_d;

    // State and repeat-interval counter registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state: a debounced release always wins over a due repeat.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise_s[g]) begin
            pulse_d = 1'b1;
            state_d = ST_DELAY;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end
        ST_DELAY: begin
          if (!deb_s[g]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DELAY_LAST) begin
            pulse_d = 1'b1;
            state_d = ST_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + REP_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!deb_s[g]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == PERIOD_LAST) begin
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + REP_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign up_d_s[g] = pulse_d;
  end

  // ---------------------------------------------------------------------
  // Presets, start level and registered command pulses
  // ---------------------------------------------------------------------
  logic [NREP-1:0] key_up_q;
  logic            enter_q;
  logic            start_q;
  logic            start_d;
  logic [7:0]      hour_q;
  logic [7:0]      hour_d;
  logic [7:0]      min_q;
  logic [7:0]      min_d;
  logic [7:0]      sec_q;
  logic [7:0]      sec_d;

  // Preset next values; clr overrides any up pulse seen in the same cycle.
  always_comb begin
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    start_d = start_q ^ rise_s[IDX_START];
    if (rise_s[IDX_CLR]) begin
      hour_d = 8'd0;
      min_d  = 8'd0;
      sec_d  = 8'd0;
    end else begin
      if (up_d_s[0]) begin
        hour_d = (hour_q >= HOUR_LIM) ? 8'd0 : hour_q + 8'd1;
      end else begin
        hour_d = hour_q;
      end
      if (up_d_s[1]) begin
        min_d = (min_q >= MS_LIM) ? 8'd0 : min_q + 8'd1;
      end else begin
        min_d = min_q;
      end
      if (up_d_s[2]) begin
        sec_d = (sec_q >= MS_LIM) ? 8'd0 : sec_q + 8'd1;
      end else begin
        sec_d = sec_q;
      end
    end
  end

  // Output registers: pulses and presets change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_up_q <= '0;
      enter_q  <= 1'b0;
      start_q  <= 1'b0;
      hour_q   <= 8'd0;
      min_q    <= 8'd0;
      sec_q    <= 8'd0;
    end else begin
      key_up_q <= up_d_s;
      enter_q  <= rise_s[IDX_ENTER];
      start_q  <= start_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
    end
  end

  assign key_hour_up = key_up_q[0];
  assign key_min_up  = key_up_q[1];
  assign key_sec_up  = key_up_q[2];
  assign key_enter   = enter_q;
  assign key_start   = start_q;
  assign hour_set    = hour_q;
  assign min_set     = min_q;
  assign sec_set     = sec_q;

endmodule

// File: tb/tb_time_set_keys.sv
// Testbench for time_set_keys with small timing parameters. A reference model
// tracks raw samples per button as a sample history window and schedules
// pulses by absolute edge number; scenario tasks compare against it.
module tb_time_set_keys;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;
  localparam int HM  = 23;
  localparam int MM  = 59;

  logic       clk;
  logic       rst;
  logic       btn_hour, btn_min, btn_sec, btn_enter, btn_start, btn_clr;
  logic       key_hour_up, key_min_up, key_sec_up, key_enter, key_start;
  logic [7:0] hour_set, min_set, sec_set;

  time_set_keys #(
    .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP), .HOUR_MAX(HM), .MS_MAX(MM)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_hour(btn_hour), .btn_min(btn_min), .btn_sec(btn_sec),
    .btn_enter(btn_enter), .btn_start(btn_start), .btn_clr(btn_clr),
    .key_hour_up(key_hour_up), .key_min_up(key_min_up), .key_sec_up(key_sec_up),
    .key_enter(key_enter), .key_start(key_start),
    .hour_set(hour_set), .min_set(min_set), .sec_set(sec_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_no = 0;

  // reference model state
  logic [15:0] m_hist [6];
  logic [5:0]  m_dnow, m_dold;
  logic [2:0]  m_up, m_active;
  logic        m_enter, m_start;
  int          m_due [3];
  int          m_hour, m_min, m_sec;

  logic [28:0] obs_v, exp_v;
  assign obs_v = {key_hour_up, key_min_up, key_sec_up, key_enter, key_start,
                  hour_set, min_set, sec_set};
  assign exp_v = {m_up[0], m_up[1], m_up[2], m_enter, m_start,
                  m_hour[7:0], m_min[7:0], m_sec[7:0]};

  task automatic model_reset();
    for (int b = 0; b < 6; b++) m_hist[b] = '0;
    m_dnow = '0; m_dold = '0; m_up = '0; m_active = '0;
    m_enter = 1'b0; m_start = 1'b0;
    for (int g = 0; g < 3; g++) m_due[g] = 0;
    m_hour = 0; m_min = 0; m_sec = 0;
  endtask

  // A level is accepted once the DEB samples taken two edges back and earlier
  // all disagree with the current accepted level.
  task automatic model_edge();
    logic [5:0] raw, rise, dprev;
    logic       flip;
    edge_no++;
    raw = {btn_clr, btn_start, btn_enter, btn_sec, btn_min, btn_hour};
    if (rst) begin
      model_reset();
      return;
    end
    rise  = m_dnow & ~m_dold;
    dprev = m_dnow;
    for (int b = 0; b < 6; b++) begin
      m_hist[b] = {m_hist[b][14:0], raw[b]};
      flip = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) if (m_hist[b][k] == m_dnow[b]) flip = 1'b0;
      m_dold[b] = m_dnow[b];
      if (flip) m_dnow[b] = ~m_dnow[b];
    end
    for (int g = 0; g < 3; g++) begin
      m_up[g] = 1'b0;
      if (rise[g]) begin
        m_up[g] = 1'b1; m_active[g] = 1'b1; m_due[g] = edge_no + RD;
      end else if (m_active[g] && dprev[g] && edge_no == m_due[g]) begin
        m_up[g] = 1'b1; m_due[g] = edge_no + RP;
      end
      if (!dprev[g]) m_active[g] = 1'b0;
    end
    m_enter = rise[3];
    if (rise[4]) m_start = ~m_start;
    if (m_up[0]) m_hour = (m_hour + 1) % (HM + 1);
    if (m_up[1]) m_min  = (m_min + 1) % (MM + 1);
    if (m_up[2]) m_sec  = (m_sec + 1) % (MM + 1);
    if (rise[5]) begin m_hour = 0; m_min = 0; m_sec = 0; end
  endtask

  // advance one clock; returns at the following negedge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_hour  = v;
      1: btn_min   = v;
      2: btn_sec   = v;
      3: btn_enter = v;
      4: btn_start = v;
      5: btn_clr   = v;
      default: ;
    endcase
  endtask

  task automatic press(input logic [5:0] mask, input int hold);
    for (int b = 0; b < 6; b++) if (mask[b]) set_btn(b, 1'b1);
    for (int c = 0; c < hold; c++) tick();
    for (int b = 0; b < 6; b++) if (mask[b]) set_btn(b, 1'b0);
    for (int c = 0; c < 12; c++) tick();
  endtask

  // From a preset of 0, hold long enough that the release lands right after
  // the pulse giving target-1; the next repeat (still before the debounced
  // fall) brings the preset to exactly target. Needs target >= 3.
  task automatic hold_to(input int idx, input int target);
    set_btn(idx, 1'b1);
    for (int c = 0; c < 1 + DEB + 2 + RD + RP * (target - 3); c++) tick();
    set_btn(idx, 1'b0);
    for (int c = 0; c < 12; c++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_hour = 0; btn_min = 0; btn_sec = 0; btn_enter = 0; btn_start = 0; btn_clr = 0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (obs_v !== 29'd0) begin
        bad++; $display("FAIL reset_outputs got=%h want=0", obs_v);
      end
    end
    rst = 1'b0;
    tick();
    total++;
    if (obs_v !== exp_v) begin
      bad++; $display("FAIL reset_release got=%h want=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_glitch();
    int np = 0;
    btn_min = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) btn_min = 1'b0;
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL glitch_model c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (key_min_up) np++;
    end
    total++;
    if (np !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", np); end
    total++;
    if (min_set !== 8'd0) begin bad++; $display("FAIL glitch_min got=%0d want=0", min_set); end
  endtask

  task automatic test_single_press();
    int np = 0;
    int pe = -1;
    int k  = edge_no;
    btn_hour = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) btn_hour = 1'b0;
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL single_model c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (key_hour_up) begin np++; pe = edge_no; end
    end
    total++;
    if (np !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", np); end
    total++;
    if (pe !== k + 1 + DEB + 2) begin
      bad++; $display("FAIL single_edge got=%0d want=%0d", pe, k + 1 + DEB + 2);
    end
    total++;
    if (hour_set !== 8'd1) begin bad++; $display("FAIL single_hour got=%0d want=1", hour_set); end
  endtask

  task automatic test_repeat();
    int got[$];
    int want[$];
    int n    = edge_no + 1;
    int last = n + 60 + 1 + DEB;  // last edge with the debounced level still high
    int t;
    want.push_back(n + DEB + 2);
    t = n + DEB + 2 + RD;
    while (t <= last) begin want.push_back(t); t += RP; end
    btn_sec = 1'b1;
    for (int c = 0; c < 75; c++) begin
      if (c == 60) btn_sec = 1'b0;
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL repeat_model c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (key_sec_up) got.push_back(edge_no);
    end
    total++;
    if (got.size() !== want.size()) begin
      bad++; $display("FAIL repeat_count got=%0d want=%0d", got.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        total++;
        if (got[i] !== want[i]) begin
          bad++; $display("FAIL repeat_edge i=%0d got=%0d want=%0d", i, got[i] - n, want[i] - n);
        end
      end
    end
    total++;
    if (sec_set !== 8'(want.size())) begin
      bad++; $display("FAIL repeat_sec got=%0d want=%0d", sec_set, want.size());
    end
  endtask

  task automatic test_wrap();
    press(6'b100000, 8);
    hold_to(0, 23);
    hold_to(1, 59);
    hold_to(2, 4);
    total++;
    if ({hour_set, min_set, sec_set} !== {8'd23, 8'd59, 8'd4}) begin
      bad++; $display("FAIL wrap_preload got=%0d/%0d/%0d want=23/59/4", hour_set, min_set, sec_set);
    end
    press(6'b000011, 8);
    total++;
    if ({hour_set, min_set, sec_set} !== {8'd0, 8'd0, 8'd4}) begin
      bad++; $display("FAIL wrap_result got=%0d/%0d/%0d want=0/0/4", hour_set, min_set, sec_set);
    end
    total++;
    if (obs_v !== exp_v) begin bad++; $display("FAIL wrap_model got=%h want=%h", obs_v, exp_v); end
  endtask

  task automatic test_start();
    logic prev;
    logic want;
    int   toggles;
    int   te;
    int   k;
    for (int p = 0; p < 2; p++) begin
      want = (p == 0) ? 1'b1 : 1'b0;
      prev = key_start;
      toggles = 0;
      te = -1;
      k = edge_no;
      btn_start = 1'b1;
      for (int c = 0; c < 20; c++) begin
        if (c == 8) btn_start = 1'b0;
        tick();
        total++;
        if (obs_v !== exp_v) begin
          bad++; $display("FAIL start_model p=%0d c=%0d got=%h want=%h", p, c, obs_v, exp_v);
        end
        if (key_start !== prev) begin toggles++; te = edge_no; prev = key_start; end
      end
      total++;
      if (toggles !== 1) begin bad++; $display("FAIL start_toggles p=%0d got=%0d want=1", p, toggles); end
      total++;
      if (te !== k + 1 + DEB + 2) begin
        bad++; $display("FAIL start_edge p=%0d got=%0d want=%0d", p, te, k + 1 + DEB + 2);
      end
      total++;
      if (key_start !== want) begin bad++; $display("FAIL start_level p=%0d got=%b want=%b", p, key_start, want); end
    end
  endtask

  task automatic test_clr_collision();
    bit found = 1'b0;
    int fe = -1;
    int k;
    press(6'b100000, 8);
    hold_to(0, 5);
    hold_to(1, 6);
    hold_to(2, 7);
    total++;
    if ({hour_set, min_set, sec_set} !== {8'd5, 8'd6, 8'd7}) begin
      bad++; $display("FAIL clr_preload got=%0d/%0d/%0d want=5/6/7", hour_set, min_set, sec_set);
    end
    k = edge_no;
    btn_clr = 1'b1; btn_hour = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 8) begin btn_clr = 1'b0; btn_hour = 1'b0; end
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL clr_model c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (key_hour_up && !found) begin
        found = 1'b1;
        fe = edge_no;
        total++;
        if ({hour_set, min_set, sec_set} !== 24'd0) begin
          bad++; $display("FAIL clr_presets got=%0d/%0d/%0d want=0/0/0", hour_set, min_set, sec_set);
        end
      end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL clr_hour_pulse got=none want=pulse");
    end else if (fe !== k + 1 + DEB + 2) begin
      bad++; $display("FAIL clr_edge got=%0d want=%0d", fe, k + 1 + DEB + 2);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int np = 0;
    int pe = -1;
    int k;
    btn_sec = 1'b1;
    for (int c = 0; c < 45; c++) begin
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL midrst_model c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
    end
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (obs_v !== 29'd0) begin bad++; $display("FAIL midrst_async got=%h want=0", obs_v); end
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b0;
    k = edge_no;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL midrst_after c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
      if (key_sec_up) begin np++; pe = edge_no; end
    end
    total++;
    if (np !== 1 || pe !== k + 1 + DEB + 2) begin
      bad++; $display("FAIL midrst_pulse got=%0d@%0d want=1@%0d", np, pe - k, 1 + DEB + 2);
    end
    total++;
    if (sec_set !== 8'd1) begin bad++; $display("FAIL midrst_sec got=%0d want=1", sec_set); end
    btn_sec = 1'b0;
    for (int c = 0; c < 12; c++) tick();
  endtask

  task automatic test_random();
    int         rem [6];
    logic [5:0] lvl;
    lvl = '0;
    for (int b = 0; b < 6; b++) rem[b] = $urandom_range(1, 30);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 6; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = ~lvl[b];
          rem[b] = (($urandom & 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60);
        end
        rem[b]--;
        set_btn(b, lvl[b]);
      end
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL random_model c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
    end
    for (int b = 0; b < 6; b++) set_btn(b, 1'b0);
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL random_tail c=%0d got=%h want=%h", c, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_press();
    test_repeat();
    test_wrap();
    test_start();
    test_clr_collision();
    test_reset_mid_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
